// File: rtl/encoded_rr_reader_if.sv
// Bundle of the bank-side pop interface and the consumer-side output stream
// for encoded_rr_reader. "master" is the reader, "slave" is the bank/consumer side.
interface encoded_rr_reader_if #(
    parameter int NUM_FIFOS = 4,
    parameter int WIDTH     = 8,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
);
    logic [NUM_FIFOS-1:0] empty;
    logic [WIDTH-1:0]     data_in;
    logic                 req;
    logic [TAGWIDTH-1:0]  gnt_sel;
    logic [WIDTH-1:0]     out_data;
    logic [TAGWIDTH-1:0]  out_tag;
    logic                 out_vld;
    logic                 out_rdy;

    // Output stream: a beat transfers on a rising clk edge where out_vld & out_rdy;
    // out_vld never depends on out_rdy, and out_data/out_tag hold while out_vld & !out_rdy.
    modport master (
        input  empty, data_in, out_rdy,
        output req, gnt_sel, out_data, out_tag, out_vld
    );
    modport slave (
        output empty, data_in, out_rdy,
        input  req, gnt_sel, out_data, out_tag, out_vld
    );
endinterface

// File: rtl/encoded_rr_reader.sv
// Round-robin reader for an encoded-select FIFO bank: pops one non-empty FIFO per
// cycle and queues {tag,data} in a 2-entry output buffer drained by valid/ready.
module encoded_rr_reader #(
    parameter int NUM_FIFOS = 4,
    parameter int WIDTH     = 8,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
    input  logic                clk,
    input  logic                rst,
    encoded_rr_reader_if.master bus
);
    localparam logic [TAGWIDTH-1:0] LAST  = TAGWIDTH'(NUM_FIFOS - 1);
    localparam logic [TAGWIDTH:0]   NUM_W = (TAGWIDTH + 1)'(NUM_FIFOS);

    logic [TAGWIDTH-1:0] ptr_q, ptr_d;
    logic [1:0]          count_q, count_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic [WIDTH-1:0]    data_q [2];
    logic [WIDTH-1:0]    data_d [2];
    logic [TAGWIDTH-1:0] tag_q [2];
    logic [TAGWIDTH-1:0] tag_d [2];

    logic [TAGWIDTH-1:0] cand;
    logic                found;
    logic [TAGWIDTH:0]   sum;
    logic                req;
    logic [TAGWIDTH-1:0] gnt_sel;
    logic                pop;

    // Scan ptr, ptr+1, ... with an explicit wrap at NUM_FIFOS (not at 2**TAGWIDTH).
    always_comb begin
        cand  = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            sum = {1'b0, ptr_q} + (TAGWIDTH + 1)'(k);
            if (sum >= NUM_W) sum = sum - NUM_W;
            if (!found && !bus.empty[sum[TAGWIDTH-1:0]]) begin
                found = 1'b1;
                cand  = sum[TAGWIDTH-1:0];
            end
        end
    end

    // Space is judged on the registered count only, so out_rdy never reaches req.
    always_comb begin
        req     = !rst && found && (count_q != 2'd2);
        gnt_sel = req ? cand : ptr_q;
    end

    always_comb begin
        pop     = (count_q != 2'd0) && bus.out_rdy;
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (req) begin
            data_d[wr_q] = bus.data_in;
            tag_d[wr_q]  = gnt_sel;
            wr_d         = ~wr_q;
            ptr_d        = (gnt_sel == LAST) ? '0 : gnt_sel + 1'b1;
        end
        if (pop) rd_d = ~rd_q;
        case ({req, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.req      = req;
    assign bus.gnt_sel  = gnt_sel;
    assign bus.out_vld  = (count_q != 2'd0);
    assign bus.out_data = data_q[rd_q];
    assign bus.out_tag  = tag_q[rd_q];
endmodule

// File: tb/tb_encoded_rr_reader.sv
// Randomized and directed checks of encoded_rr_reader against a queue-based model
// of the round-robin reader; a second 3-FIFO instance checks the non-power-of-2 wrap.
module tb_encoded_rr_reader;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TW = 2;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    encoded_rr_reader_if #(.NUM_FIFOS(N), .WIDTH(W)) bus ();
    encoded_rr_reader_if #(.NUM_FIFOS(3), .WIDTH(W)) bus3 ();

    encoded_rr_reader #(.NUM_FIFOS(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    encoded_rr_reader #(.NUM_FIFOS(3), .WIDTH(W)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // 3-FIFO instance: every FIFO always non-empty, consumer always ready.
    assign bus3.empty   = '0;
    assign bus3.data_in = {6'h30, bus3.gnt_sel};
    assign bus3.out_rdy = 1'b1;

    // FIFO bank: per-FIFO storage written by the stimulus, popped by the DUT's req.
    logic [W-1:0] mem [N][DEPTH];
    int wp [N];
    int rp [N];

    always_comb begin
        for (int i = 0; i < N; i++) bus.empty[i] = (rp[i] >= wp[i]);
        bus.data_in = (int'(bus.gnt_sel) < N) ? mem[bus.gnt_sel][rp[bus.gnt_sel] % DEPTH] : '0;
    end

    always @(posedge clk) begin
        if (bus.req && int'(bus.gnt_sel) < N) rp[bus.gnt_sel] <= rp[bus.gnt_sel] + 1;
    end

    // Reference model: source queues by read index, an expected output queue, a start pointer.
    logic [TW+W-1:0] exp_q [$];
    int mrp [N];
    int ptr_m;
    int n3_cnt;
    int errors;
    int checks;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_src(input int f, input logic [W-1:0] v);
        mem[f][wp[f]] = v;
        wp[f]++;
    endtask

    task automatic model_check();
        int  g;
        bit  any;
        bit  exp_req;
        int  idx;
        any = 1'b0;
        g   = ptr_m;
        for (int k = 0; k < N; k++) begin
            idx = (ptr_m + k) % N;
            if (!any && mrp[idx] < wp[idx]) begin
                any = 1'b1;
                g   = idx;
            end
        end
        exp_req = any && (exp_q.size() < 2);
        check_eq("req", 32'(bus.req), 32'(exp_req));
        check_eq("gnt_sel", 32'(bus.gnt_sel), 32'(exp_req ? g : ptr_m));
        check_eq("out_vld", 32'(bus.out_vld), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check_eq("out_head", 32'({bus.out_tag, bus.out_data}), 32'(exp_q[0]));
        if (n3_cnt < 9) begin
            check_eq("n3_gnt_sel", 32'(bus3.gnt_sel), 32'(n3_cnt % 3));
            check_eq("n3_req", 32'(bus3.req), 32'd1);
            n3_cnt++;
        end
        if (exp_q.size() != 0 && bus.out_rdy) void'(exp_q.pop_front());
        if (exp_req) begin
            exp_q.push_back({TW'(g), mem[g][mrp[g]]});
            mrp[g]++;
            ptr_m = (g + 1) % N;
        end
    endtask

    task automatic step(input bit rdy);
        bus.out_rdy = rdy;
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    // Raise reset between clock edges, check the asynchronous effect, release after an edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_req", 32'(bus.req), 32'd0);
        check_eq("rst_out_vld", 32'(bus.out_vld), 32'd0);
        check_eq("rst_gnt_sel", 32'(bus.gnt_sel), 32'd0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_out_tag", 32'(bus.out_tag), 32'd0);
        exp_q.delete();
        ptr_m = 0;
        @(posedge clk);
        #1;
        check_eq("rst_req_held", 32'(bus.req), 32'd0);
        rst    = 1'b0;
        n3_cnt = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        n3_cnt = 99;
        bus.out_rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            wp[i]  = 0;
            rp[i]  = 0;
            mrp[i] = 0;
        end

        // Power-on reset with every FIFO non-empty, then round-robin 0,1,2,3,0...
        for (int i = 0; i < N; i++) begin
            push_src(i, W'($urandom));
            push_src(i, W'($urandom));
        end
        #1;
        do_reset();
        for (int c = 0; c < 12; c++) step(1'b1);

        // Lone FIFO 2 from ptr 0 leaves ptr at 3; then FIFOs 0 and 2 -> FIFO 0 wins.
        do_reset();
        push_src(2, 8'h52);
        for (int c = 0; c < 3; c++) step(1'b1);
        push_src(0, 8'h50);
        push_src(2, 8'h53);
        for (int c = 0; c < 5; c++) step(1'b1);

        // Stalled consumer: exactly two pops, then ordered drain resuming at tag 2.
        do_reset();
        for (int i = 0; i < N; i++) push_src(i, W'(8'hA0 + i));
        for (int c = 0; c < 4; c++) step(1'b0);
        for (int c = 0; c < 8; c++) step(1'b1);

        // Single busy FIFO with ready consumer: push and pop every cycle.
        for (int v = 0; v < 6; v++) push_src(1, W'(8'h10 + v));
        for (int c = 0; c < 9; c++) step(1'b1);

        // Reset while the buffer is full; nothing stale may appear afterwards.
        for (int i = 0; i < N; i++) begin
            push_src(i, W'($urandom));
            push_src(i, W'($urandom));
            push_src(i, W'($urandom));
        end
        for (int c = 0; c < 3; c++) step(1'b0);
        do_reset();
        for (int c = 0; c < 14; c++) step(1'b1);

        // Random traffic and back-pressure, with one reset in the middle.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 30 && wp[i] < DEPTH - 4) push_src(i, W'($urandom));
            end
            if (c == 200) do_reset();
            step($urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 40; c++) step(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
